// File: rtl/overcooked_pkg.sv
// Shared types for the order/score producer.
// - dish_t   : the four dishes a chef can cook
// - order_t  : one pending order (dish and remaining lifetime in vsync ticks)
// - SCORE_MAX: saturation value of the 4-bit score
// - lfsr_next: one step of the 8-bit Fibonacci LFSR (taps 8,6,5,4, shift left)
package overcooked_pkg;

  typedef enum logic [1:0] {
    DISH_ONION  = 2'd0,
    DISH_TOMATO = 2'd1,
    DISH_SALAD  = 2'd2,
    DISH_BURGER = 2'd3
  } dish_t;

  // Lifetime field is called "remaining" because "time" is a reserved word.
  typedef struct packed {
    dish_t       dish;
    logic [11:0] remaining;
  } order_t;

  localparam logic [3:0] SCORE_MAX = 4'd15;

  // Feedback is the XOR of bits 7,5,4,3 (taps 8,6,5,4), shifted into bit 0.
  // A nonzero state never maps to zero.
  function automatic logic [7:0] lfsr_next(input logic [7:0] s);
    return {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
  endfunction

endpackage

// File: rtl/order_lfsr.sv
// Pseudo-random dish source for newly spawned orders.
// Ports:
//   clk     in  1  frame clock (vsync)
//   Reset   in  1  asynchronous, active-high; loads SEED
//   advance in  1  step the LFSR once on this edge
//   state   out 8  current LFSR state; the caller uses state[1:0] as the dish
module order_lfsr
  import overcooked_pkg::*;
#(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       Reset,
  input  logic       advance,
  output logic [7:0] state
);

  // LFSR state register; only moves when a spawn actually happens.
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      state <= SEED;
    end else if (advance) begin
      state <= lfsr_next(state);
    end else begin
      state <= state;
    end
  end

endmodule

// File: rtl/order_manager.sv
// Order queue and score producer for the HUD.
// Spawns dish orders at a fixed frame interval while the round runs, ages
// them, drops timed-out ones, matches deliveries against the oldest pending
// order of the same dish, and publishes the score and order list.
// Ports:
//   vsync         in  1               frame clock
//   Reset         in  1               asynchronous, active-high
//   StartFlag     in  1               round running
//   EndFlag       in  1               round over
//   deliver_valid in  1               single-tick delivery strobe
//   deliver_dish  in  2               dish being delivered
//   deliver_ack   out 1               delivery matched an order
//   deliver_nack  out 1               delivery matched nothing
//   expired       out 1               at least one order timed out
//   score         out 4               completed deliveries, saturating at 15
//   order_count   out 4               valid queue entries
//   order_dish    out 2*MAX_ORDERS    entry i dish at [2i+1:2i], entry 0 oldest
//   order_time    out 12*MAX_ORDERS   entry i remaining ticks at [12i+11:12i]
module order_manager
  import overcooked_pkg::*;
#(
  parameter int         MAX_ORDERS   = 4,
  parameter int         ORDER_FRAMES = 3600,
  parameter int         SPAWN_FRAMES = 1200,
  parameter logic [7:0] LFSR_SEED    = 8'hA5
) (
  input  logic                      vsync,
  input  logic                      Reset,
  input  logic                      StartFlag,
  input  logic                      EndFlag,
  input  logic                      deliver_valid,
  input  logic [1:0]                deliver_dish,
  output logic                      deliver_ack,
  output logic                      deliver_nack,
  output logic                      expired,
  output logic [3:0]                score,
  output logic [3:0]                order_count,
  output logic [2*MAX_ORDERS-1:0]   order_dish,
  output logic [12*MAX_ORDERS-1:0]  order_time
);

  // A one-tick spawn period still needs a 1-bit counter to hold zero.
  localparam int              CW         = (SPAWN_FRAMES > 1) ? $clog2(SPAWN_FRAMES) : 1;
  localparam int              IW         = $clog2(MAX_ORDERS);
  localparam logic [CW-1:0]   SPAWN_LAST = CW'(SPAWN_FRAMES - 1);
  localparam logic [11:0]     ORDER_INIT = 12'(ORDER_FRAMES);
  localparam logic [3:0]      DEPTH      = 4'(MAX_ORDERS);

  order_t            queue_r [MAX_ORDERS];
  order_t            queue_s [MAX_ORDERS];
  order_t            aged_s  [MAX_ORDERS];
  logic [3:0]        count_r;
  logic [3:0]        count_s;
  logic [3:0]        score_r;
  logic [3:0]        score_s;
  logic [CW-1:0]     spawn_cnt_r;
  logic [CW-1:0]     spawn_cnt_s;
  logic              ack_r;
  logic              ack_s;
  logic              nack_r;
  logic              nack_s;
  logic              expired_r;
  logic              expired_s;
  logic              run_s;
  logic              advance_s;
  logic [7:0]        lfsr_s;
  logic              lfsr_unused_s;
  logic [MAX_ORDERS-1:0] keep_s;
  logic              hit_s;
  logic [3:0]        fill_s;

  assign run_s         = StartFlag & ~EndFlag;
  assign lfsr_unused_s = ^lfsr_s[7:2];

  order_lfsr #(
    .SEED (LFSR_SEED)
  ) u_lfsr (
    .clk     (vsync),
    .Reset   (Reset),
    .advance (advance_s),
    .state   (lfsr_s)
  );

  // Age, deliver, spawn and compact: one frame of queue evolution.
  always_comb begin
    queue_s     = '{default: '0};
    aged_s      = '{default: '0};
    keep_s      = '0;
    hit_s       = 1'b0;
    fill_s      = 4'd0;
    count_s     = count_r;
    score_s     = score_r;
    spawn_cnt_s = spawn_cnt_r;
    ack_s       = 1'b0;
    nack_s      = 1'b0;
    expired_s   = 1'b0;
    advance_s   = 1'b0;

    if (run_s) begin
      // Age: an entry holding 1 reaches 0 now and is dropped.
      for (int i = 0; i < MAX_ORDERS; i++) begin
        if (4'(i) < count_r) begin
          aged_s[i].dish      = queue_r[i].dish;
          aged_s[i].remaining = queue_r[i].remaining - 12'd1;
          if (queue_r[i].remaining == 12'd1) begin
            expired_s = 1'b1;
          end else begin
            keep_s[i] = 1'b1;
          end
        end else begin
          aged_s[i] = '0;
        end
      end

      // Deliver: only survivors of aging are eligible, oldest first.
      if (deliver_valid) begin
        for (int i = 0; i < MAX_ORDERS; i++) begin
          if (keep_s[i] && !hit_s && (aged_s[i].dish == dish_t'(deliver_dish))) begin
            keep_s[i] = 1'b0;
            hit_s     = 1'b1;
          end else begin
            keep_s[i] = keep_s[i];
          end
        end
        if (hit_s) begin
          ack_s   = 1'b1;
          score_s = (score_r == SCORE_MAX) ? SCORE_MAX : score_r + 4'd1;
        end else begin
          nack_s  = 1'b1;
        end
      end else begin
        hit_s = 1'b0;
      end

      // Stable compaction of the surviving entries towards index 0.
      for (int i = 0; i < MAX_ORDERS; i++) begin
        if (keep_s[i]) begin
          queue_s[fill_s[IW-1:0]] = aged_s[i];
          fill_s                  = fill_s + 4'd1;
        end else begin
          fill_s = fill_s;
        end
      end

      // Spawn into the first free slot, which may have been freed this frame.
      if ((spawn_cnt_r == '0) && (fill_s < DEPTH)) begin
        queue_s[fill_s[IW-1:0]].dish      = dish_t'(lfsr_s[1:0]);
        queue_s[fill_s[IW-1:0]].remaining = ORDER_INIT;
        fill_s                            = fill_s + 4'd1;
        advance_s                         = 1'b1;
      end else begin
        advance_s = 1'b0;
      end

      spawn_cnt_s = (spawn_cnt_r == SPAWN_LAST) ? '0 : spawn_cnt_r + 1'b1;
      count_s     = fill_s;
    end else begin
      queue_s = queue_r;
    end
  end

  // Committed queue, score, spawn timer and one-tick status flags.
  always_ff @(posedge vsync or posedge Reset) begin
    if (Reset) begin
      queue_r     <= '{default: '0};
      count_r     <= 4'd0;
      score_r     <= 4'd0;
      spawn_cnt_r <= '0;
      ack_r       <= 1'b0;
      nack_r      <= 1'b0;
      expired_r   <= 1'b0;
    end else begin
      queue_r     <= queue_s;
      count_r     <= count_s;
      score_r     <= score_s;
      spawn_cnt_r <= spawn_cnt_s;
      ack_r       <= ack_s;
      nack_r      <= nack_s;
      expired_r   <= expired_s;
    end
  end

  // Flatten the registered queue onto the renderer buses.
  always_comb begin
    order_dish = '0;
    order_time = '0;
    for (int i = 0; i < MAX_ORDERS; i++) begin
      order_dish[2*i +: 2]   = queue_r[i].dish;
      order_time[12*i +: 12] = queue_r[i].remaining;
    end
  end

  assign deliver_ack  = ack_r;
  assign deliver_nack = nack_r;
  assign expired      = expired_r;
  assign score        = score_r;
  assign order_count  = count_r;

endmodule

// File: tb/tb_order_manager.sv
module tb_order_manager;

  localparam int MAXO  = 4;
  localparam int ORDER = 20;
  localparam int SPAWN = 4;

  logic              vsync = 1'b0;
  logic              Reset;
  logic              StartFlag;
  logic              EndFlag;
  logic              deliver_valid;
  logic [1:0]        deliver_dish;
  logic              deliver_ack;
  logic              deliver_nack;
  logic              expired;
  logic [3:0]        score;
  logic [3:0]        order_count;
  logic [2*MAXO-1:0] order_dish;
  logic [12*MAXO-1:0] order_time;

  int checks = 0;
  int errors = 0;

  order_manager #(
    .MAX_ORDERS   (MAXO),
    .ORDER_FRAMES (ORDER),
    .SPAWN_FRAMES (SPAWN),
    .LFSR_SEED    (8'hA5)
  ) dut (
    .vsync         (vsync),
    .Reset         (Reset),
    .StartFlag     (StartFlag),
    .EndFlag       (EndFlag),
    .deliver_valid (deliver_valid),
    .deliver_dish  (deliver_dish),
    .deliver_ack   (deliver_ack),
    .deliver_nack  (deliver_nack),
    .expired       (expired),
    .score         (score),
    .order_count   (order_count),
    .order_dish    (order_dish),
    .order_time    (order_time)
  );

  always #5 vsync = ~vsync;

  // ---------------- reference model: a list of pending orders ----------------
  typedef struct { int dish; int t; } mord_t;
  mord_t      mq[$];
  mord_t      nq[$];
  int         m_score;
  int         m_spawn;
  logic [7:0] m_lfsr;
  int         m_ack, m_nack, m_exp;

  task automatic model_reset();
    mq.delete();
    m_score = 0; m_spawn = 0; m_lfsr = 8'hA5;
    m_ack = 0; m_nack = 0; m_exp = 0;
  endtask

  task automatic model_step(bit run, bit dv, int dish);
    int hit;
    m_ack = 0; m_nack = 0; m_exp = 0;
    if (run) begin
      nq.delete();
      foreach (mq[i]) begin
        if (mq[i].t - 1 == 0) m_exp = 1;
        else nq.push_back('{mq[i].dish, mq[i].t - 1});
      end
      if (dv) begin
        hit = -1;
        foreach (nq[i]) if (hit < 0 && nq[i].dish == dish) hit = i;
        if (hit >= 0) begin
          nq.delete(hit);
          m_ack = 1;
          if (m_score < 15) m_score++;
        end else begin
          m_nack = 1;
        end
      end
      if (m_spawn == 0 && nq.size() < MAXO) begin
        nq.push_back('{int'(m_lfsr[1:0]), ORDER});
        m_lfsr = {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
      end
      m_spawn = (m_spawn + 1) % SPAWN;
      mq = nq;
    end
  endtask

  // ---------------- helpers ----------------
  task automatic chk(string name, int act, int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic compare_all(string tag);
    chk({tag, ".count"}, int'(order_count), mq.size());
    chk({tag, ".score"}, int'(score), m_score);
    chk({tag, ".ack"}, int'(deliver_ack), m_ack);
    chk({tag, ".nack"}, int'(deliver_nack), m_nack);
    chk({tag, ".expired"}, int'(expired), m_exp);
    for (int i = 0; i < MAXO; i++) begin
      int ed = 0;
      int et = 0;
      if (i < mq.size()) begin
        ed = mq[i].dish;
        et = mq[i].t;
      end
      chk($sformatf("%s.dish%0d", tag, i), int'(order_dish[2*i +: 2]), ed);
      chk($sformatf("%s.time%0d", tag, i), int'(order_time[12*i +: 12]), et);
    end
  endtask

  task automatic tick(bit st, bit en, bit dv, int dish);
    StartFlag     = st;
    EndFlag       = en;
    deliver_valid = dv;
    deliver_dish  = dish[1:0];
    @(posedge vsync);
    #1;
    model_step(st && !en, dv, dish);
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    bit st; bit en; bit dv; int dish;
    int count; int scr; int ack; int nack; int exp; int dish0; int time0;
  } vec_t;
  vec_t tbl[12];

  int  found;
  int  pre;
  int  d;
  int  twin;
  bit  run_b, en_b, dv_b;
  int  dsh;

  initial begin
    // Hand-derived from reset: LFSR A5 -> dishes 1,2,1,...; SPAWN=4, ORDER=20.
    tbl[0]  = '{1,0,0,0, 1,0,0,0,0, 1,20};
    tbl[1]  = '{1,0,1,3, 1,0,0,1,0, 1,19};
    tbl[2]  = '{1,0,1,1, 0,1,1,0,0, 0,0};
    tbl[3]  = '{1,0,0,0, 0,1,0,0,0, 0,0};
    tbl[4]  = '{1,0,0,0, 1,1,0,0,0, 2,20};
    tbl[5]  = '{0,0,1,2, 1,1,0,0,0, 2,20};
    tbl[6]  = '{1,1,1,2, 1,1,0,0,0, 2,20};
    tbl[7]  = '{1,0,0,0, 1,1,0,0,0, 2,19};
    tbl[8]  = '{1,0,1,0, 1,1,0,1,0, 2,18};
    tbl[9]  = '{1,0,0,0, 1,1,0,0,0, 2,17};
    tbl[10] = '{1,0,0,0, 2,1,0,0,0, 2,16};
    tbl[11] = '{1,0,1,1, 1,2,1,0,0, 2,15};

    Reset = 1'b1; StartFlag = 1'b0; EndFlag = 1'b0;
    deliver_valid = 1'b0; deliver_dish = 2'd0;
    model_reset();
    #12;
    Reset = 1'b0;
    #1;
    compare_all("reset");

    // Table phase (model tracks along for later phases).
    for (int r = 0; r < 12; r++) begin
      tick(tbl[r].st, tbl[r].en, tbl[r].dv, tbl[r].dish);
      chk($sformatf("vec%0d.count", r), int'(order_count), tbl[r].count);
      chk($sformatf("vec%0d.score", r), int'(score), tbl[r].scr);
      chk($sformatf("vec%0d.ack", r), int'(deliver_ack), tbl[r].ack);
      chk($sformatf("vec%0d.nack", r), int'(deliver_nack), tbl[r].nack);
      chk($sformatf("vec%0d.expired", r), int'(expired), tbl[r].exp);
      chk($sformatf("vec%0d.dish0", r), int'(order_dish[1:0]), tbl[r].dish0);
      chk($sformatf("vec%0d.time0", r), int'(order_time[11:0]), tbl[r].time0);
    end
    chk("vec.second_entry_dish", int'(order_dish[3:2]), 0);

    // Expiring order delivered in its expiry tick, with no surviving twin -> nack.
    found = 0;
    for (int k = 0; k < 200 && found == 0; k++) begin
      d = -1;
      foreach (mq[i]) begin
        if (d < 0 && mq[i].t == 1) begin
          twin = 0;
          foreach (mq[j]) if (j != i && mq[j].t > 1 && mq[j].dish == mq[i].dish) twin = 1;
          if (twin == 0) d = mq[i].dish;
        end
      end
      if (d >= 0) begin
        tick(1, 0, 1, d);
        found = 1;
        chk("expdel.expired", int'(expired), 1);
        chk("expdel.nack", int'(deliver_nack), 1);
        chk("expdel.ack", int'(deliver_ack), 0);
        compare_all("expdel");
      end else begin
        tick(1, 0, 0, 0);
        compare_all("age");
      end
    end
    if (found == 0) chk("expdel.reached", 0, 1);

    // Randomized run against the model.
    for (int k = 0; k < 300; k++) begin
      run_b = ($urandom_range(0, 9) != 0);
      en_b  = ($urandom_range(0, 19) == 0);
      dv_b  = $urandom_range(0, 1);
      if (mq.size() > 0 && $urandom_range(0, 1) == 1)
        dsh = mq[$urandom_range(0, mq.size() - 1)].dish;
      else
        dsh = $urandom_range(0, 3);
      tick(run_b, en_b, dv_b, dsh);
      compare_all("rand");
    end

    // Asynchronous reset in the middle of a frame.
    tick(1, 0, 0, 0);
    compare_all("pre_reset");
    Reset = 1'b1;
    #1;
    chk("midreset.count", int'(order_count), 0);
    chk("midreset.score", int'(score), 0);
    chk("midreset.ack", int'(deliver_ack), 0);
    chk("midreset.nack", int'(deliver_nack), 0);
    chk("midreset.expired", int'(expired), 0);
    chk("midreset.order_dish", int'(order_dish), 0);
    chk("midreset.order_time_lo", int'(order_time[31:0]), 0);
    chk("midreset.order_time_hi", int'(order_time[47:32]), 0);
    model_reset();
    #1;
    Reset = 1'b0;

    // Drive the score to saturation, then one more matching delivery.
    found = 0;
    for (int k = 0; k < 500 && found == 0; k++) begin
      pre = m_score;
      if (mq.size() > 0) tick(1, 0, 1, mq[0].dish);
      else tick(1, 0, 0, 0);
      compare_all("sat");
      if (pre == 15 && m_ack == 1) begin
        found = 1;
        chk("sat.score_held", int'(score), 15);
        chk("sat.ack_at_max", int'(deliver_ack), 1);
      end
    end
    if (found == 0) chk("sat.reached", 0, 1);

    // End screen: times and score frozen, deliveries ignored.
    for (int k = 0; k < 3; k++) begin
      tick(1, 1, 1, (mq.size() > 0) ? mq[0].dish : 0);
      compare_all("endscr");
      chk("endscr.ack", int'(deliver_ack), 0);
      chk("endscr.nack", int'(deliver_nack), 0);
      chk("endscr.score", int'(score), 15);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
